// File: rtl/check_scan_ctrl.sv
// ---------------------------------------------------------------------------
// check_scan_ctrl
//   Debug scan sequencer for the pipeline hazard/forwarding check mux.
//   On a start request it freezes the CPU, lets the pipeline settle for
//   HALT_WAIT cycles, then walks check_addr over entries 0..N_ENTRY-1.
//   Each captured (addr, data) pair is offered to the debug unit over a
//   valid/ready port. After the last beat it pulses done and releases
//   the CPU. An abort returns the sequencer to idle without a done pulse.
//
// Ports
//   clk_i          clock, all state changes on the rising edge
//   rstn_i         synchronous reset, active-low
//   start_i        scan request, only looked at while idle
//   abort_i        cancel a scan in progress, ignored while idle
//   cpu_halt_o     1 = CPU clock-enable held off
//   check_addr_o   entry select into the check mux
//   check_data_i   check mux output (combinational from check_addr_o)
//   out_valid_o    captured beat available
//   out_ready_i    debug unit accepts the beat when valid & ready
//   out_addr_o     entry index of the current beat
//   out_data_o     captured check data of the current beat
//   busy_o         1 in every state except idle
//   done_o         one-cycle pulse after a complete scan
// ---------------------------------------------------------------------------
module check_scan_ctrl #(
  parameter int unsigned N_ENTRY   = 25,
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned HALT_WAIT = 2
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              start_i,
  input  logic              abort_i,
  output logic              cpu_halt_o,
  output logic [ADDR_W-1:0] check_addr_o,
  input  logic [DATA_W-1:0] check_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [ADDR_W-1:0] out_addr_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic              busy_o,
  output logic              done_o
);

  // Settle counter only has to reach HALT_WAIT-1; keep at least one bit so
  // the HALT_WAIT=0/1 builds still elaborate (the counter is unused there).
  localparam int unsigned CNT_W       = (HALT_WAIT > 32'd1) ? $clog2(HALT_WAIT) : 32'd1;
  localparam int unsigned SETTLE_LAST = (HALT_WAIT > 32'd0) ? (HALT_WAIT - 32'd1) : 32'd0;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SETTLE_LAST);
  localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(N_ENTRY - 32'd1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETTLE = 3'd1,
    S_SCAN   = 3'd2,
    S_SEND   = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [ADDR_W-1:0]   check_addr_q, check_addr_d;
  logic                cpu_halt_q, cpu_halt_d;
  logic                out_valid_q, out_valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  // Next-state, scan index, settle counter and beat capture.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    out_addr_d = out_addr_q;
    out_data_d = out_data_q;

    case (state_q)
      S_IDLE: begin
        idx_d = '0;
        cnt_d = '0;
        if (start_i) begin
          // With no settle time the first entry is selected straight away.
          state_d = (HALT_WAIT == 32'd0) ? S_SCAN : S_SETTLE;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_SETTLE: begin
        if (abort_i) begin
          state_d = S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_SCAN;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_SCAN: begin
        if (abort_i) begin
          state_d = S_IDLE;
        end else begin
          // check_addr has been stable for this whole cycle, so the mux
          // output is valid to capture at this edge.
          state_d    = S_SEND;
          out_addr_d = idx_q;
          out_data_d = check_data_i;
        end
      end

      S_SEND: begin
        // Abort takes priority over a handshake in the same cycle.
        if (abort_i) begin
          state_d = S_IDLE;
        end else if (out_ready_i) begin
          if (idx_q == IDX_LAST) begin
            state_d = S_DONE;
          end else begin
            state_d = S_SCAN;
            idx_d   = idx_q + ADDR_W'(1);
          end
        end else begin
          state_d = S_SEND;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end

      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // Registered outputs are decoded from the next state so they line up
  // with the state they describe.
  always_comb begin
    cpu_halt_d   = 1'b0;
    out_valid_d  = 1'b0;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    check_addr_d = '0;

    case (state_d)
      S_IDLE: begin
        busy_d = 1'b0;
      end
      S_SETTLE: begin
        cpu_halt_d = 1'b1;
        busy_d     = 1'b1;
      end
      S_SCAN: begin
        cpu_halt_d   = 1'b1;
        busy_d       = 1'b1;
        check_addr_d = idx_d;
      end
      S_SEND: begin
        cpu_halt_d   = 1'b1;
        busy_d       = 1'b1;
        out_valid_d  = 1'b1;
        check_addr_d = idx_d;
      end
      S_DONE: begin
        // CPU is released in the same cycle that done pulses.
        busy_d = 1'b1;
        done_d = 1'b1;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      out_addr_q   <= '0;
      out_data_q   <= '0;
      check_addr_q <= '0;
      cpu_halt_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      out_addr_q   <= out_addr_d;
      out_data_q   <= out_data_d;
      check_addr_q <= check_addr_d;
      cpu_halt_q   <= cpu_halt_d;
      out_valid_q  <= out_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign cpu_halt_o   = cpu_halt_q;
  assign check_addr_o = check_addr_q;
  assign out_valid_o  = out_valid_q;
  assign out_addr_o   = out_addr_q;
  assign out_data_o   = out_data_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;

endmodule
